// File: rtl/period_pkg.sv
// Shared types and constants for the period-4 pattern generator.
package period_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int         PAT_DEPTH = 4;
  localparam int         PRIME_LEN = 4;
  localparam logic [7:0] ERR_MASK  = 8'h01;
endpackage

// File: rtl/pattern_regfile.sv
// 4x8 pattern store: one synchronous write port, one combinational read port.
module pattern_regfile
  import period_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr,
  output logic [7:0] rdata
);
  logic [7:0] mem_q [PAT_DEPTH];
  logic [7:0] mem_d [PAT_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PAT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/period_pattern_gen.sv
// Burst generator replaying a 4-byte pattern, with error injection and a
// registered period-4 "expected match" flag for downstream checkers.
module period_pattern_gen
  import period_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] burst_len,
  input  logic        err_inject,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        exp_sign,
  output logic        busy,
  output logic        done
);
  state_t                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [15:0]            len_q, len_d;
  logic [PRIME_LEN-1:0]   hist_q, hist_d;
  logic [7:0]             data_out_q, data_out_d;
  logic                   valid_q, valid_d;
  logic                   exp_q, exp_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [1:0]             rd_addr;
  logic [7:0]             rd_data;
  logic                   last_word;

  // Pattern is frozen while a burst runs so the period-4 relation holds.
  pattern_regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we & ~busy_q),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    hist_d     = hist_q;
    data_out_d = '0;
    valid_d    = 1'b0;
    exp_d      = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    rd_addr    = (state_q == ST_IDLE) ? 2'd0 : idx_q;
    last_word  = (len_q != 16'd0) && (cnt_q == len_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d      = burst_len;
          idx_d      = 2'd1;
          cnt_d      = 16'd1;
          hist_d     = '0;
          state_d    = ST_PRIME;
          data_out_d = rd_data;
          valid_d    = 1'b1;
          busy_d     = 1'b1;
        end
      end
      default: begin
        // A natural end wins over a coincident stop so done still pulses.
        if (last_word) begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
          done_d  = 1'b1;
        end else if (stop) begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
        end else begin
          data_out_d = err_inject ? (rd_data ^ ERR_MASK) : rd_data;
          valid_d    = 1'b1;
          busy_d     = 1'b1;
          exp_d      = (state_q == ST_RUN) && !err_inject && !hist_q[PRIME_LEN-1];
          hist_d     = {hist_q[PRIME_LEN-2:0], err_inject};
          idx_d      = idx_q + 2'd1;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if ((state_q == ST_PRIME) && (cnt_d == 16'(PRIME_LEN))) state_d = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      hist_q     <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      exp_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      hist_q     <= hist_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      exp_q      <= exp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign exp_sign   = exp_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_period_pattern_gen.sv
// Directed bench for period_pattern_gen: inputs driven and outputs sampled on the falling edge.
module tb_period_pattern_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        start;
  logic        stop;
  logic [15:0] burst_len;
  logic        err_inject;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        exp_sign;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pat     [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] s2_data [10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h23, 8'h33, 8'h44, 8'h11, 8'h22};
  logic       s2_sign [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  period_pattern_gen dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .start      (start),
    .stop       (stop),
    .burst_len  (burst_len),
    .err_inject (err_inject),
    .data_out   (data_out),
    .data_valid (data_valid),
    .exp_sign   (exp_sign),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [7:0] d, input logic s);
    chk({tag, "_valid"}, 16'(data_valid), 16'd1);
    chk({tag, "_data"},  16'(data_out),   16'(d));
    chk({tag, "_sign"},  16'(exp_sign),   16'(s));
    chk({tag, "_busy"},  16'(busy),       16'd1);
    chk({tag, "_done"},  16'(done),       16'd0);
  endtask

  task automatic chk_end(input string tag, input logic d);
    chk({tag, "_valid"}, 16'(data_valid), 16'd0);
    chk({tag, "_data"},  16'(data_out),   16'd0);
    chk({tag, "_sign"},  16'(exp_sign),   16'd0);
    chk({tag, "_busy"},  16'(busy),       16'd0);
    chk({tag, "_done"},  16'(done),       16'(d));
  endtask

  task automatic write_slot(input logic [1:0] a, input logic [7:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic kick(input logic [15:0] len);
    burst_len = len;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; stop = 1'b0; burst_len = '0; err_inject = 1'b0;
    step(); step();
    chk_end("reset", 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) write_slot(2'(i), pat[i]);

    // Plain 10-word burst
    kick(16'd10);
    for (int i = 0; i < 10; i++) begin
      chk_word("s1_word", pat[i % 4], (i >= 4));
      step();
    end
    chk_end("s1_end", 1'b1);
    step();
    chk("s1_done_once", 16'(done), 16'd0);

    // Error injected ahead of word 6 also kills the sign of word 10
    kick(16'd10);
    for (int i = 0; i < 10; i++) begin
      chk_word("s2_word", s2_data[i], s2_sign[i]);
      err_inject = (i == 4);
      step();
    end
    err_inject = 1'b0;
    chk_end("s2_end", 1'b1);
    step();

    // Continuous burst aborted after 20 words
    kick(16'd0);
    for (int i = 0; i < 20; i++) begin
      chk_word("s3_word", pat[i % 4], (i >= 4));
      stop = (i == 19);
      step();
    end
    stop = 1'b0;
    chk_end("s3_stop", 1'b0);
    step();
    chk_end("s3_idle", 1'b0);

    // Pattern write during a burst is dropped; written after, it takes
    kick(16'd6);
    for (int i = 0; i < 6; i++) begin
      chk_word("s4_word", pat[i % 4], (i >= 4));
      cfg_we   = (i == 1);
      cfg_addr = 2'd0;
      cfg_data = 8'hFF;
      step();
    end
    cfg_we = 1'b0;
    chk_end("s4_end", 1'b1);
    step();
    write_slot(2'd0, 8'hFF);
    kick(16'd1);
    chk_word("s4_new", 8'hFF, 1'b0);
    step();
    chk_end("s4_new_end", 1'b1);
    step();

    // Reset at word 3 clears outputs and the pattern store
    kick(16'd10);
    for (int i = 0; i < 3; i++) begin
      chk_word("s5_word", (i == 0) ? 8'hFF : pat[i], 1'b0);
      rst = (i == 2);
      step();
    end
    rst = 1'b0;
    chk_end("s5_rst", 1'b0);
    kick(16'd1);
    chk_word("s5_cleared", 8'h00, 1'b0);
    step();
    chk_end("s5_cleared_end", 1'b1);
    step();
    for (int i = 0; i < 4; i++) write_slot(2'(i), pat[i]);
    kick(16'd5);
    for (int i = 0; i < 5; i++) begin
      chk_word("s5_restart", pat[i % 4], (i >= 4));
      step();
    end
    chk_end("s5_restart_end", 1'b1);
    step();

    // Start+stop in IDLE starts; start while busy is ignored
    burst_len = 16'd8;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_word("s6_word", pat[i % 4], (i >= 4));
      start = (i == 2);
      step();
    end
    start = 1'b0;
    chk_end("s6_end", 1'b1);
    step();

    // Stop coinciding with the last word still ends normally
    kick(16'd3);
    for (int i = 0; i < 3; i++) begin
      chk_word("s7_word", pat[i], 1'b0);
      stop = (i == 2);
      step();
    end
    stop = 1'b0;
    chk_end("s7_end", 1'b1);
    step();
    chk("s7_done_once", 16'(done), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
